// File: rtl/xh_touch_ctrl_if.sv
// ---------------------------------------------------------------------------
// xh_touch_ctrl_if
// Touch-panel input bundle for the front-panel UI controller.
//   touch_valid : level, finger down
//   touch_x     : touch column, active-area pixels (X_BITS)
//   touch_y     : touch row, active-area pixels (Y_BITS)
//   vs_in       : frame sync from the video timing generator
// Modports: master = panel/timing side (drives), slave = controller (samples).
// ---------------------------------------------------------------------------
interface xh_touch_ctrl_if #(
   parameter int unsigned X_BITS = 13,
   parameter int unsigned Y_BITS = 13
);
   logic              touch_valid;
   logic [X_BITS-1:0] touch_x;
   logic [Y_BITS-1:0] touch_y;
   logic              vs_in;

   modport master (output touch_valid, touch_x, touch_y, vs_in);
   modport slave  (input  touch_valid, touch_x, touch_y, vs_in);
endinterface

// File: rtl/xh_touch_ctrl.sv
// ---------------------------------------------------------------------------
// xh_touch_ctrl
// Touch-panel UI controller: hit-tests touch coordinates against the seven
// on-screen buttons, debounces press/release, runs the menu settings and
// reports the highlighted button once per frame.
//
// Ports
//   pix_clk    in   single clock, rising edge
//   rstn       in   synchronous active-low reset
//   tp         in   xh_touch_ctrl_if.slave (touch_valid, touch_x, touch_y, vs_in)
//   hl_id      out  button highlighted this frame, 0 = none
//   mode       out  0 MAIN, 1 FREQ_ADJ, 2 AMP_ADJ
//   wave_sel   out  waveform select
//   freq_code  out  frequency setting
//   amp_code   out  amplitude setting
//   evt_pulse  out  1-cycle strobe per accepted button event
//   rst_req    out  1-cycle soft-reset request (with the RST event strobe)
//
// Build option: define XH_AUTOREPEAT_EN to enable auto-repeat of PLUS/MINUS
// while held (REP_DLY first delay, REP_CYC period). Without it each press
// yields exactly one event and no repeat logic exists.
// ---------------------------------------------------------------------------
module xh_touch_ctrl #(
   parameter int unsigned X_BITS   = 13,
   parameter int unsigned Y_BITS   = 13,
   parameter int unsigned CODE_W   = 8,
   parameter int unsigned DEB_CYC  = 16,
   parameter int unsigned FREQ_DEF = 10,
   parameter int unsigned AMP_DEF  = 50,
   parameter int unsigned REP_DLY  = 64,
   parameter int unsigned REP_CYC  = 16
) (
   input  logic              pix_clk,
   input  logic              rstn,
   xh_touch_ctrl_if.slave    tp,
   output logic [2:0]        hl_id,
   output logic [1:0]        mode,
   output logic [1:0]        wave_sel,
   output logic [CODE_W-1:0] freq_code,
   output logic [CODE_W-1:0] amp_code,
   output logic              evt_pulse,
   output logic              rst_req
);

   localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);

   localparam logic [2:0] ID_NONE  = 3'd0;
   localparam logic [2:0] ID_WAVE  = 3'd1;
   localparam logic [2:0] ID_FREQ  = 3'd2;
   localparam logic [2:0] ID_AMP   = 3'd3;
   localparam logic [2:0] ID_BACK  = 3'd4;
   localparam logic [2:0] ID_PLUS  = 3'd5;
   localparam logic [2:0] ID_MINUS = 3'd6;
   localparam logic [2:0] ID_RST   = 3'd7;

   localparam logic [1:0] MODE_MAIN = 2'd0;
   localparam logic [1:0] MODE_FREQ = 2'd1;
   localparam logic [1:0] MODE_AMP  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEB  = 2'd1,
      ST_HELD = 2'd2,
      ST_REL  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        cand_q, cand_d;
   logic [2:0]        hit_c;
   logic [2:0]        id_q;
   logic              armed_q;
   logic              fire_c;

   logic              evt_q;
   logic              rst_req_q;
   logic [2:0]        ev_id_q;
   logic              vs_q;
   logic [2:0]        hl_q;
   logic [1:0]        mode_q;
   logic [1:0]        wave_q;
   logic [CODE_W-1:0] freq_q;
   logic [CODE_W-1:0] amp_q;

`ifdef XH_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REP_DLY > REP_CYC) ? REP_DLY : REP_CYC;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_first_q, rep_first_d;
   logic             rep_stop_q, rep_stop_d;
   logic             rep_btn_c;

   assign rep_btn_c = (cand_q == ID_PLUS) || (cand_q == ID_MINUS);
`else
   // Repeat timing has no hardware in this build.
   if (REP_DLY == 0 || REP_CYC == 0) begin : g_rep_cfg_ignored
   end
`endif

   // Inclusive rectangle test; rectangles match the button-background renderer.
   function automatic logic in_rect(input logic [X_BITS-1:0] x,
                                    input logic [Y_BITS-1:0] y,
                                    input int unsigned x0, input int unsigned x1,
                                    input int unsigned y0, input int unsigned y1);
      return (x >= X_BITS'(x0)) && (x <= X_BITS'(x1)) &&
             (y >= Y_BITS'(y0)) && (y <= Y_BITS'(y1));
   endfunction

   // Button hit test (rectangles are disjoint).
   always_comb begin
      hit_c = ID_NONE;
      if (tp.touch_valid) begin
         if      (in_rect(tp.touch_x, tp.touch_y,  16,  240, 244, 356)) hit_c = ID_WAVE;
         else if (in_rect(tp.touch_x, tp.touch_y, 272,  496, 244, 356)) hit_c = ID_FREQ;
         else if (in_rect(tp.touch_x, tp.touch_y, 272,  496, 444, 556)) hit_c = ID_AMP;
         else if (in_rect(tp.touch_x, tp.touch_y, 780, 1004,  44, 156)) hit_c = ID_BACK;
         else if (in_rect(tp.touch_x, tp.touch_y, 528,  752, 244, 356)) hit_c = ID_PLUS;
         else if (in_rect(tp.touch_x, tp.touch_y, 528,  752, 444, 556)) hit_c = ID_MINUS;
         else if (in_rect(tp.touch_x, tp.touch_y,  16,  240, 444, 556)) hit_c = ID_RST;
      end
   end

   // Press FSM: state register.
   always_ff @(posedge pix_clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cand_q  <= ID_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
      end
   end

   // Press FSM: next state and event strobe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      fire_c  = 1'b0;
`ifdef XH_AUTOREPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      rep_stop_d  = rep_stop_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            // armed_q blocks a finger still down from before a reset.
            if (id_q != ID_NONE && armed_q) begin
               state_d = ST_DEB;
               cand_d  = id_q;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_DEB: begin
            if (cnt_q == CNT_W'(DEB_CYC)) begin
               fire_c  = 1'b1;
               state_d = ST_HELD;
`ifdef XH_AUTOREPEAT_EN
               rep_cnt_d   = REP_W'(1);
               rep_first_d = 1'b1;
               rep_stop_d  = 1'b0;
`endif
            end else if (id_q == ID_NONE) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (id_q == cand_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cand_d = id_q;
               cnt_d  = CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (!tp.touch_valid) begin
               state_d = ST_REL;
               cnt_d   = CNT_W'(1);
`ifdef XH_AUTOREPEAT_EN
               rep_stop_d = 1'b1;
            end else if (id_q != cand_q || !rep_btn_c || mode_q == MODE_MAIN) begin
               // Once the finger leaves the button the repeat stays off for this press.
               rep_stop_d = 1'b1;
            end else if (!rep_stop_q) begin
               if (rep_cnt_q == (rep_first_q ? REP_W'(REP_DLY) : REP_W'(REP_CYC))) begin
                  fire_c      = 1'b1;
                  rep_cnt_d   = REP_W'(1);
                  rep_first_d = 1'b0;
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
`endif
            end
         end
         ST_REL: begin
            // cnt_q counts consecutive released samples, the entry sample included.
            if (tp.touch_valid) begin
               state_d = ST_HELD;
            end else if (cnt_q >= CNT_W'(DEB_CYC - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef XH_AUTOREPEAT_EN
   // Auto-repeat timer.
   always_ff @(posedge pix_clk) begin
      if (!rstn) begin
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
         rep_stop_q  <= 1'b1;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
         rep_stop_q  <= rep_stop_d;
      end
   end
`endif

   // Registered hit id, re-arm flag, event strobes and frame highlight.
   always_ff @(posedge pix_clk) begin
      if (!rstn) begin
         id_q      <= ID_NONE;
         armed_q   <= 1'b0;
         evt_q     <= 1'b0;
         rst_req_q <= 1'b0;
         ev_id_q   <= ID_NONE;
         vs_q      <= 1'b0;
         hl_q      <= ID_NONE;
      end else begin
         id_q      <= hit_c;
         if (!tp.touch_valid) armed_q <= 1'b1;
         evt_q     <= fire_c;
         rst_req_q <= fire_c && (cand_q == ID_RST);
         ev_id_q   <= cand_q;
         vs_q      <= tp.vs_in;
         if (tp.vs_in && !vs_q)
            hl_q <= (state_q != ST_IDLE) ? cand_q : ID_NONE;
      end
   end

   // Setting registers, updated the cycle after the event strobe.
   always_ff @(posedge pix_clk) begin
      if (!rstn) begin
         mode_q <= MODE_MAIN;
         wave_q <= 2'd0;
         freq_q <= CODE_W'(FREQ_DEF);
         amp_q  <= CODE_W'(AMP_DEF);
      end else if (evt_q) begin
         case (ev_id_q)
            ID_WAVE: wave_q <= wave_q + 2'd1;
            ID_FREQ: mode_q <= MODE_FREQ;
            ID_AMP:  mode_q <= MODE_AMP;
            ID_BACK: mode_q <= MODE_MAIN;
            ID_PLUS: begin
               if (mode_q == MODE_FREQ && freq_q != '1) freq_q <= freq_q + CODE_W'(1);
               if (mode_q == MODE_AMP  && amp_q  != '1) amp_q  <= amp_q  + CODE_W'(1);
            end
            ID_MINUS: begin
               if (mode_q == MODE_FREQ && freq_q != '0) freq_q <= freq_q - CODE_W'(1);
               if (mode_q == MODE_AMP  && amp_q  != '0) amp_q  <= amp_q  - CODE_W'(1);
            end
            ID_RST: begin
               mode_q <= MODE_MAIN;
               wave_q <= 2'd0;
               freq_q <= CODE_W'(FREQ_DEF);
               amp_q  <= CODE_W'(AMP_DEF);
            end
            default: ;
         endcase
      end
   end

   assign hl_id     = hl_q;
   assign mode      = mode_q;
   assign wave_sel  = wave_q;
   assign freq_code = freq_q;
   assign amp_code  = amp_q;
   assign evt_pulse = evt_q;
   assign rst_req   = rst_req_q;

endmodule

// File: tb/tb_xh_touch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xh_touch_ctrl
// Randomized and directed presses checked against a press-level model: an
// event is expected for the first run of >= DEB identical non-zero hit ids in
// a press, DEB+1 cycles after the run starts; settings follow the button
// actions. Define XH_AUTOREPEAT_EN for both RTL and bench to cover repeat.
// ---------------------------------------------------------------------------
module tb_xh_touch_ctrl;
   localparam int unsigned X_BITS   = 13;
   localparam int unsigned Y_BITS   = 13;
   localparam int unsigned CODE_W   = 8;
   localparam int unsigned DEB      = 4;
   localparam int unsigned FREQ_DEF = 10;
   localparam int unsigned AMP_DEF  = 50;
   localparam int unsigned REP_DLY  = 8;
   localparam int unsigned REP_CYC  = 4;
   localparam int          CODE_MAX = (1 << CODE_W) - 1;

   logic              pix_clk = 1'b0;
   logic              rstn;
   logic [2:0]        hl_id;
   logic [1:0]        mode;
   logic [1:0]        wave_sel;
   logic [CODE_W-1:0] freq_code;
   logic [CODE_W-1:0] amp_code;
   logic              evt_pulse;
   logic              rst_req;

   xh_touch_ctrl_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) tp ();

   xh_touch_ctrl #(
      .X_BITS(X_BITS), .Y_BITS(Y_BITS), .CODE_W(CODE_W), .DEB_CYC(DEB),
      .FREQ_DEF(FREQ_DEF), .AMP_DEF(AMP_DEF), .REP_DLY(REP_DLY), .REP_CYC(REP_CYC)
   ) dut (
      .pix_clk   (pix_clk),
      .rstn      (rstn),
      .tp        (tp),
      .hl_id     (hl_id),
      .mode      (mode),
      .wave_sel  (wave_sel),
      .freq_code (freq_code),
      .amp_code  (amp_code),
      .evt_pulse (evt_pulse),
      .rst_req   (rst_req)
   );

   always #5 pix_clk = ~pix_clk;

   // Button rectangles, index = button id.
   int RX0 [8] = '{0,  16, 272, 272,  780, 528, 528,  16};
   int RX1 [8] = '{0, 240, 496, 496, 1004, 752, 752, 240};
   int RY0 [8] = '{0, 244, 244, 444,   44, 244, 444, 444};
   int RY1 [8] = '{0, 356, 356, 556,  156, 356, 556, 556};

   int n_cmp = 0;
   int n_bad = 0;

   // Model settings.
   int m_mode = 0;
   int m_wave = 0;
   int m_freq = FREQ_DEF;
   int m_amp  = AMP_DEF;
   int m_hl   = 0;

   // Press samples (touch_valid=1 for all of them).
   int px[$];
   int py[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int hit(input int x, input int y);
      for (int b = 1; b < 8; b++)
         if (x >= RX0[b] && x <= RX1[b] && y >= RY0[b] && y <= RY1[b]) return b;
      return 0;
   endfunction

   task automatic apply(input int id);
      case (id)
         1: m_wave = (m_wave + 1) % 4;
         2: m_mode = 1;
         3: m_mode = 2;
         4: m_mode = 0;
         5: begin
            if (m_mode == 1 && m_freq < CODE_MAX) m_freq++;
            if (m_mode == 2 && m_amp  < CODE_MAX) m_amp++;
         end
         6: begin
            if (m_mode == 1 && m_freq > 0) m_freq--;
            if (m_mode == 2 && m_amp  > 0) m_amp--;
         end
         7: begin
            m_mode = 0; m_wave = 0; m_freq = FREQ_DEF; m_amp = AMP_DEF;
         end
         default: ;
      endcase
   endtask

   // Random point inside button b, corners favoured.
   task automatic pt_in(input int b, output int x, output int y);
      if ($urandom_range(0, 3) == 0) begin
         x = $urandom_range(0, 1) ? RX1[b] : RX0[b];
         y = $urandom_range(0, 1) ? RY1[b] : RY0[b];
      end else begin
         x = $urandom_range(RX1[b], RX0[b]);
         y = $urandom_range(RY1[b], RY0[b]);
      end
   endtask

   // Point just outside a random button edge.
   task automatic pt_out(output int x, output int y);
      int b;
      b = $urandom_range(1, 7);
      case ($urandom_range(0, 3))
         0: begin x = RX0[b] - 1; y = $urandom_range(RY1[b], RY0[b]); end
         1: begin x = RX1[b] + 1; y = $urandom_range(RY1[b], RY0[b]); end
         2: begin x = $urandom_range(RX1[b], RX0[b]); y = RY0[b] - 1; end
         default: begin x = $urandom_range(RX1[b], RX0[b]); y = RY1[b] + 1; end
      endcase
      if (hit(x, y) != 0) begin x = 2000; y = 2000; end
   endtask

   task automatic add_btn(input int b, input int n);
      int x, y;
      for (int k = 0; k < n; k++) begin
         if (b == 0) begin
            if (k == 0) pt_out(x, y);
         end else begin
            pt_in(b, x, y);
         end
         px.push_back(x);
         py.push_back(y);
      end
   endtask

   task automatic add_pt(input int x, input int y, input int n);
      for (int k = 0; k < n; k++) begin
         px.push_back(x);
         py.push_back(y);
      end
   endtask

   // Drive the queued press then rel_len released cycles, checking every cycle.
   task automatic do_press(input int rel_len, input int rst_at, input int vs_at, input int vs_val);
      int n, w, s, len, cand, lim, x, y;
      int ids[];
      int ev[];
      n = px.size();
      w = n + rel_len;
      ids = new[n > 0 ? n : 1];
      ev  = new[w];
      for (int i = 0; i < w; i++) ev[i] = 0;
      for (int i = 0; i < n; i++) ids[i] = hit(px[i], py[i]);

      if (rst_at < 0) begin
         int i;
         i = 0;
         cand = 0;
         while (i < n && cand == 0) begin
            if (ids[i] == 0) begin
               i++;
            end else begin
               int j;
               j = i;
               while (j < n && ids[j] == ids[i]) j++;
               if (j - i >= DEB) begin
                  s = i; len = j - i; cand = ids[i];
                  ev[s + DEB + 1] = cand;
               end
               i = j;
            end
         end
`ifdef XH_AUTOREPEAT_EN
         if ((cand == 5 || cand == 6) && m_mode != 0) begin
            lim = (s + len < n - 1) ? s + len : n - 1;
            for (int t = s + DEB + 1 + REP_DLY; t <= lim; t += REP_CYC) ev[t] = cand;
         end
`endif
      end

      for (int i = 0; i < w; i++) begin
         if (i < n) begin
            tp.touch_valid = 1'b1;
            tp.touch_x     = X_BITS'(px[i]);
            tp.touch_y     = Y_BITS'(py[i]);
         end else begin
            // Released finger with stale coordinates inside a button must not hit.
            pt_in($urandom_range(1, 7), x, y);
            tp.touch_valid = 1'b0;
            tp.touch_x     = X_BITS'(x);
            tp.touch_y     = Y_BITS'(y);
         end
         tp.vs_in = (i == vs_at);
         rstn     = (i != rst_at);
         @(posedge pix_clk);
         #1;
         if (i == rst_at) begin
            m_mode = 0; m_wave = 0; m_freq = FREQ_DEF; m_amp = AMP_DEF; m_hl = 0;
         end
         if (i == vs_at) m_hl = vs_val;
         chk("evt_pulse", int'(evt_pulse), int'(ev[i] != 0));
         chk("rst_req",   int'(rst_req),   int'(ev[i] == 7));
         chk("mode",      int'(mode),      m_mode);
         chk("wave_sel",  int'(wave_sel),  m_wave);
         chk("freq_code", int'(freq_code), m_freq);
         chk("amp_code",  int'(amp_code),  m_amp);
         chk("hl_id",     int'(hl_id),     m_hl);
         if (ev[i] != 0) apply(ev[i]);
      end
      rstn     = 1'b1;
      tp.vs_in = 1'b0;
      px.delete();
      py.delete();
   endtask

   task automatic quick(input int b);
      add_btn(b, DEB + 1);
      do_press(DEB + 3, -1, -1, 0);
   endtask

   initial begin
      int f0;
      rstn           = 1'b0;
      tp.touch_valid = 1'b0;
      tp.touch_x     = '0;
      tp.touch_y     = '0;
      tp.vs_in       = 1'b0;
      repeat (3) @(posedge pix_clk);
      #1;
      rstn = 1'b1;

      // Reset state, then idle frame edge gives no highlight.
      do_press(4, -1, -1, 0);
      do_press(6, -1, 2, 0);

      // WAVE at (100,300) held 10 cycles; frame edge while held highlights it.
      add_pt(100, 300, 10);
      do_press(DEB + 3, -1, 8, 1);

      // FREQ then three PLUS.
      quick(2);
      quick(5); quick(5); quick(5);
      chk("freq_after_3plus", int'(freq_code), FREQ_DEF + 3);

      // Slide from FREQ (2 cycles) onto PLUS (6 cycles): only PLUS fires.
      add_pt(400, 300, 2);
      add_pt(600, 300, 6);
      do_press(DEB + 3, -1, -1, 0);

      // Highlight returns to 0 on an idle frame edge.
      do_press(6, -1, 3, 0);

      // AMP mode saturation at both ends.
      quick(3);
      for (int k = 0; k < CODE_MAX - AMP_DEF + 3; k++) quick(5);
      chk("amp_sat_hi", int'(amp_code), CODE_MAX);
      for (int k = 0; k < CODE_MAX + 3; k++) quick(6);
      chk("amp_sat_lo", int'(amp_code), 0);

      // RST after changes.
      quick(1);
      quick(7);
      chk("rst_mode", int'(mode), 0);
      chk("rst_amp",  int'(amp_code), AMP_DEF);

      // Reset in the middle of a press: no event until a fresh press.
      quick(3);
      add_btn(1, 14);
      do_press(DEB + 3, 3, -1, 0);
      quick(1);

      // Held PLUS in FREQ mode (repeats only with auto-repeat).
      quick(2);
      f0 = int'(freq_code);
      add_pt(600, 300, 30);
      do_press(DEB + 3, -1, -1, 0);
`ifdef XH_AUTOREPEAT_EN
      chk("hold_plus_delta", int'(freq_code) - f0, 6);
`else
      chk("hold_plus_delta", int'(freq_code) - f0, 1);
`endif

      // Random multi-segment presses.
      for (int p = 0; p < 150; p++) begin
         int nseg;
         nseg = $urandom_range(1, 3);
         for (int sg = 0; sg < nseg; sg++) begin
            int r, b;
            r = $urandom_range(0, 9);
            b = (r == 8) ? 5 : (r == 9) ? 6 : r;
            add_btn(b, $urandom_range(1, (sg == nseg - 1) ? 14 : 7));
         end
         do_press(DEB + 3 + $urandom_range(0, 3), -1, -1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
